// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types for the line timers and coordinate generator
package vga_pkg;
  typedef enum logic [1:0] {SYNC, BACKPORCH, ACTIVE, FRONTPORCH} VGA_state_e;
  typedef enum logic {V_IDLE, V_RUN} vga_vstate_e;
  localparam int VGA_MAX_SYNC_DELAY = 15;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage resettable shift register, DEPTH=0 is a wire
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) sr <= '{default: '0};
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_coord_gen.sv
// vga_coord_gen: active-area x/y, data enable, line/frame strobes and aligned syncs.
// Define VGA_COORD_CHECK_EN to add the sticky timing_err line-length/wrap checker.
module vga_coord_gen
  import vga_pkg::*;
#(
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12,
  parameter int SYNC_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  VGA_state_e         h_state,
  input  logic               h_sync,
  input  VGA_state_e         v_state,
  input  logic               v_sync,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_COORD_CHECK_EN
  ,
  output logic               timing_err
`endif
);
  localparam int DLY = SYNC_DELAY > VGA_MAX_SYNC_DELAY ? VGA_MAX_SYNC_DELAY : SYNC_DELAY;
  VGA_state_e  h_state_q, v_state_q;
  vga_vstate_e vst;
  logic        first_line;
  logic [2:0]  raw;
  logic        act, act_q, v_enter, h_fall, ls_n;
  assign act     = h_state == ACTIVE && v_state == ACTIVE;
  assign act_q   = h_state_q == ACTIVE && v_state_q == ACTIVE;
  assign v_enter = v_state == ACTIVE && v_state_q != ACTIVE;
  assign h_fall  = h_state_q == ACTIVE && h_state != ACTIVE;
  assign ls_n    = act && !act_q;
  // v_state_q resets to ACTIVE so coming out of reset mid-frame is not seen as a frame entry
  always_ff @(posedge clk) begin
    if (rst) begin
      h_state_q   <= SYNC;
      v_state_q   <= ACTIVE;
      x           <= '0;
      y           <= '0;
      vst         <= V_IDLE;
      first_line  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      raw         <= '0;
    end else begin
      h_state_q   <= h_state;
      v_state_q   <= v_state;
      x           <= act ? (act_q ? x + 1'b1 : '0) : '0;
      line_start  <= ls_n;
      frame_start <= ls_n && (vst == V_RUN ? first_line : v_enter);
      first_line  <= vst == V_IDLE ? v_enter && !ls_n : first_line && !ls_n;
      raw         <= {act, h_sync, v_sync};
      if (vst == V_IDLE) begin
        if (v_enter) begin
          vst <= V_RUN;
          y   <= '0;
        end
      end else if (v_state != ACTIVE) vst <= V_IDLE;
      else if (h_fall) y <= y + 1'b1;
    end
  end
  vga_delay_line #(.WIDTH(3), .DEPTH(DLY)) u_dly (
    .clk(clk),
    .rst(rst),
    .d  (raw),
    .q  ({de_o, hsync_o, vsync_o})
  );
`ifdef VGA_COORD_CHECK_EN
  logic [X_WIDTH-1:0] ref_len, len;
  logic               ref_pend;
  assign len = x + 1'b1;
  // x holds the last pixel index on the cycle act drops, so x+1 is the line length
  always_ff @(posedge clk) begin
    if (rst) begin
      timing_err <= 1'b0;
      ref_len    <= '0;
      ref_pend   <= 1'b0;
    end else begin
      if (vst == V_IDLE && v_enter) ref_pend <= 1'b1;
      if (raw[2] && !act && vst == V_RUN) begin
        if (ref_pend) begin
          ref_len  <= len;
          ref_pend <= 1'b0;
        end else if (ref_len != len) timing_err <= 1'b1;
      end
      if (raw[2] && x == '1) timing_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vga_coord_gen.sv
// tb_vga_coord_gen: scoreboard bench over a reduced frame with mid-frame reset
module tb_vga_coord_gen;
  import vga_pkg::*;
  localparam int HA = 20, HF = 2, HS = 3, HT = 27;
  localparam int VA = 6, VF = 1, VS = 1, VT = 9;
  localparam int NCYC = 810, RST_AT = 14 * HT + 10;

  typedef struct {
    logic        rst;
    logic [11:0] x, y;
    logic        ls, fs;
    logic [2:0]  r0, r3;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, h_sync = 1'b0, v_sync = 1'b0;
  VGA_state_e h_state = SYNC, v_state = SYNC;
  logic [11:0] x0, y0, x3, y3, yw;
  logic [3:0]  xw;
  logic de0, hs0, vs0, ls0, fs0, de3, hs3, vs3, ls3, fs3, dew, hsw, vsw, lsw, fsw;
`ifdef VGA_COORD_CHECK_EN
  logic e0, e3, ew, werr = 1'b0;
`endif
  exp_t q[$];
  logic [2:0] hist [4];
  int hc = 0, vc = VA, xm = 0, nv = 0, nf = 0, fs_seen = 0;
  logic act_prev = 1'b0, vact_prev = 1'b1, seen = 1'b0;

  always #5 clk = ~clk;

  vga_coord_gen #(.SYNC_DELAY(0)) d0 (
    .clk(clk), .rst(rst), .h_state(h_state), .h_sync(h_sync), .v_state(v_state), .v_sync(v_sync),
    .x(x0), .y(y0), .de_o(de0), .hsync_o(hs0), .vsync_o(vs0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_COORD_CHECK_EN
    , .timing_err(e0)
`endif
  );
  vga_coord_gen #(.SYNC_DELAY(3)) d3 (
    .clk(clk), .rst(rst), .h_state(h_state), .h_sync(h_sync), .v_state(v_state), .v_sync(v_sync),
    .x(x3), .y(y3), .de_o(de3), .hsync_o(hs3), .vsync_o(vs3), .line_start(ls3), .frame_start(fs3)
`ifdef VGA_COORD_CHECK_EN
    , .timing_err(e3)
`endif
  );
  vga_coord_gen #(.X_WIDTH(4), .SYNC_DELAY(0)) dw (
    .clk(clk), .rst(rst), .h_state(h_state), .h_sync(h_sync), .v_state(v_state), .v_sync(v_sync),
    .x(xw), .y(yw), .de_o(dew), .hsync_o(hsw), .vsync_o(vsw), .line_start(lsw), .frame_start(fsw)
`ifdef VGA_COORD_CHECK_EN
    , .timing_err(ew)
`endif
  );

  function automatic VGA_state_e phase(input int c, input int a, input int f, input int s);
    return c < a ? ACTIVE : c < a + f ? FRONTPORCH : c < a + f + s ? SYNC : BACKPORCH;
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nv++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // line order ACTIVE,FP,SYNC,BP; the vertical timer advances when horizontal ACTIVE ends
  task automatic step(input logic r);
    exp_t e;
    int ve;
    logic hact, vact, act;
    ve = hc < HA ? vc : (vc + 1) % VT;
    hact = hc < HA;
    vact = ve < VA;
    act = hact && vact;
    h_state = phase(hc, HA, HF, HS);
    v_state = phase(ve, VA, VF, VS);
    h_sync = h_state == SYNC;
    v_sync = v_state == SYNC;
    rst = r;
    e.rst = r;
    if (r) begin
      xm = 0; act_prev = 1'b0; vact_prev = 1'b1; seen = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      e.x = '0; e.y = '0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      if (vact && !vact_prev) seen = 1'b1;
      xm = act ? (act_prev ? xm + 1 : 0) : 0;
      e.x = 12'(xm);
      e.ls = act && !act_prev;
      e.fs = e.ls && seen && ve == 0;
      e.y = seen ? (vact ? 12'(ve) : 12'(VA - 1)) : 12'd0;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {act, h_sync, v_sync};
      act_prev = act;
      vact_prev = vact;
    end
    e.r0 = hist[0];
    e.r3 = hist[3];
    q.push_back(e);
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc + 1) % VT;
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      nv++; nf++;
      $error("FAIL scoreboard_empty got 0 expected 1");
      return;
    end
    e = q.pop_front();
    chk("x0", x0, e.x);
    chk("y0", y0, e.y);
    chk("ls0", 12'(ls0), 12'(e.ls));
    chk("fs0", 12'(fs0), 12'(e.fs));
    chk("sync0", 12'({de0, hs0, vs0}), 12'(e.r0));
    chk("x3", x3, e.x);
    chk("y3", y3, e.y);
    chk("ls3", 12'(ls3), 12'(e.ls));
    chk("fs3", 12'(fs3), 12'(e.fs));
    chk("sync3", 12'({de3, hs3, vs3}), 12'(e.r3));
    chk("xw", 12'(xw), 12'(e.x[3:0]));
    chk("yw", yw, e.y);
    chk("syncw", 12'({dew, hsw, vsw}), 12'(e.r0));
    chk("fsw", 12'(fsw), 12'(e.fs));
`ifdef VGA_COORD_CHECK_EN
    if (e.rst) werr = 1'b0;
    chk("err0", 12'(e0), 12'd0);
    chk("err3", 12'(e3), 12'd0);
    chk("errw", 12'(ew), 12'(werr));
    werr = werr | (e.x[3:0] == 4'hf && e.r0[2]);
`endif
    fs_seen += int'(fs0);
  endtask

  initial begin
    step(1'b1);
    for (int n = 1; n < NCYC; n++) begin
      @(negedge clk);
      check_out();
      step(n == RST_AT);
    end
    @(negedge clk);
    check_out();
    chk("frame_start_count", 12'(fs_seen), 12'd3);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
